// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// Single request/response transaction per access: valid/ready request, rvalid response.
interface load_store_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  localparam int unsigned STRB_W = XLEN / 8;

  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [XLEN-1:0]   bus_addr;
  logic [STRB_W-1:0] bus_wstrb;
  logic [XLEN-1:0]   bus_wdata;
  logic              bus_rvalid;
  logic [XLEN-1:0]   bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store responder for the single-cycle core: one bus transaction per access,
// stalls the core until completion and faults misaligned/illegal accesses without bus activity.
module load_store_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              stall,
  output logic              done,
  output logic              fault,
  output logic [XLEN-1:0]   rdata,
  load_store_unit_if.master bus
);
  localparam int unsigned STRB_W = XLEN / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t            state;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;

  logic              legal;
  logic              misaligned;
  logic              bad;
  logic              accept;
  logic [STRB_W-1:0] wstrb_n;
  logic [XLEN-1:0]   wdata_n;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_val;

  // Request decode: legality, alignment and handshake to the core
  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~req_we;
      default:                legal = 1'b0;
    endcase
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    bad    = ~legal | misaligned;
    accept = ~rst && (state == IDLE) && req_valid && ~bad;
    stall  = ~rst && (accept || (state == REQ) || (state == RESP));
    fault  = ~rst && (state == IDLE) && req_valid && bad;
  end

  // Store lane placement: strobes follow the byte offset, data is replicated across lanes
  always_comb begin
    wstrb_n = '0;
    wdata_n = '0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          wstrb_n = STRB_W'(1) << req_addr[1:0];
          wdata_n = {(STRB_W){req_wdata[7:0]}};
        end
        2'b01: begin
          wstrb_n = STRB_W'(3) << req_addr[1:0];
          wdata_n = {(STRB_W/2){req_wdata[15:0]}};
        end
        default: begin
          wstrb_n = '1;
          wdata_n = req_wdata;
        end
      endcase
    end
  end

  // Load extraction: align the addressed lane to bit 0, then extend
  always_comb begin
    shifted = bus.bus_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = XLEN'(shifted[7:0]);
      3'b101:  load_val = XLEN'(shifted[15:0]);
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      done          <= 1'b0;
      rdata         <= '0;
      we_q          <= 1'b0;
      funct3_q      <= '0;
      off_q         <= '0;
      bus.bus_valid <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wstrb <= '0;
      bus.bus_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            we_q          <= req_we;
            funct3_q      <= req_funct3;
            off_q         <= req_addr[1:0];
            bus.bus_valid <= 1'b1;
            bus.bus_we    <= req_we;
            bus.bus_addr  <= {req_addr[XLEN-1:2], 2'b00};
            bus.bus_wstrb <= wstrb_n;
            bus.bus_wdata <= wdata_n;
            state         <= REQ;
          end
        end
        REQ: begin
          if (bus.bus_ready) begin
            bus.bus_valid <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_wstrb <= '0;
            if (we_q) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.bus_rvalid) begin
            rdata <= load_val;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side responder for the single-cycle core's load/store path.
- Accepts a load or store issued by the datapath, which the main decoder selects via MemWE and funct3.
- Runs one transaction on a valid/ready data-memory bus and returns the byte/half/word-extended load result.
- Stalls the core until completion and flags misaligned or illegal accesses without touching the bus.

Parameters:
- XLEN, 32, data and address width; the RV32I datapath fixes this at 32.

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  core issues a load or store this cycle
- req_we  input  1  1 = store, 0 = load (MemWE)
- req_funct3  input  3  RV32I width/sign code
- req_addr  input  XLEN  byte address from the ALU
- req_wdata  input  XLEN  store data, rs2
- stall  output  1  hold PC and pipeline state
- done  output  1  one-cycle pulse when the access completes
- fault  output  1  one-cycle pulse for a misaligned or illegal access
- rdata  output  XLEN  extended load result, valid when done=1 for a load
- bus_valid  output  1  request to data memory
- bus_ready  input  1  memory accepts the request
- bus_we  output  1  write request
- bus_addr  output  XLEN  word-aligned address, {addr[31:2],2'b00}
- bus_wstrb  output  4  byte write strobes
- bus_wdata  output  XLEN  lane-replicated store data
- bus_rvalid  input  1  read data valid
- bus_rdata  input  XLEN  read word

Behaviour:
- Reset value of every output is 0 (stall, done, fault, rdata, all bus_* outputs); state = IDLE.
- Reset mid-transaction abandons the access. bus_valid is 0 from the cycle after the reset edge, and no done pulse is produced.
- FSM states and transitions:
  - IDLE: on req_valid with a legal, aligned access, latch we/funct3/addr/wdata and go to REQ.
  - REQ: drive bus_valid=1 with latched fields held stable until bus_ready=1. Store goes to DONE; load goes to RESP.
  - RESP: wait for bus_rvalid, which is sampled only in RESP. Capture the extracted bus_rdata into rdata and go to DONE.
  - DONE: done=1, stall=0, then go to IDLE. req_valid is ignored in DONE, because the core advances at the end of this cycle.
- stall (combinational) = (IDLE & req_valid & ~illegal) | REQ | RESP.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Illegal or misaligned in IDLE: fault=1 for that cycle, stall=0, done=0, no bus activity, rdata unchanged.
- Store lane mapping, with o = addr[1:0]:
  - SB: wstrb = 4'b0001<<o, wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 4'b0011<<o, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 4'b1111, wdata = wdata.
- Load extraction: shift the word right by 8*o, take the low byte or half, then sign-extend (LB/LH) or zero-extend (LBU/LHU). LW passes the word through.
- Loads drive bus_wstrb=0 and bus_we=0.
- rdata holds its value until the next load completes; stores do not modify it.
- Minimum latency, counted from the req_valid cycle as cycle 0:
  - Store: done at cycle 2.
  - Load: done at cycle 3 (bus_ready in REQ, bus_rvalid in the first RESP cycle).
- Each cycle bus_ready or bus_rvalid is low adds one cycle. There is no timeout.
- bus_rvalid arriving outside RESP is ignored.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, bus_ready=1 immediately -> bus_addr=0x100, wstrb=4'b1111, done at cycle 2, stall high cycles 0-1.
- SH addr=0x106, wdata=0x0000ABCD -> wstrb=4'b1100, bus_wdata=0xABCDABCD, bus_addr=0x104.
- LB addr=0x203, bus_rdata=0x80FF_0000, bus_ready delayed 2 cycles, rvalid 1 cycle after acceptance -> rdata=0xFFFFFF80, done at cycle 5. LBU at the same address -> rdata=0x00000080.
- LW addr=0x102 -> fault pulse in cycle 0, stall=0, bus_valid stays 0, rdata unchanged. Load funct3=3'b011 -> same response.
- Load issued, rst asserted during RESP -> next cycle state IDLE, all outputs 0, no done; a later rvalid is ignored.
- Back-to-back LH 0x300 (word 0x1234_8765 -> 0xFFFF8765) then LHU 0x302 -> second request accepted the cycle after DONE, rdata=0x00001234.
